reg_file_sb: RTL and testbench

Architectural register file with an integrated issue scoreboard: the responder to the operand-fetch stage's register-read requests. Holds the 16×32-bit register set. Serves two combinational read ports addressed by the fetch-stage selectors (rs1/ra on port 1, rs2/rd on port 2). Accepts one write per cycle from register write-back, and tracks outstanding writes per register so the operand-fetch stage can stall on RAW hazards.

---
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Architectural register file (2^ADDR_W x DATA_W) with write-through read bypass
// and a per-register outstanding-write scoreboard used for RAW stall detection.
module reg_file_sb #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 4,
  parameter int                SP_IDX  = 14,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              use1,
  input  logic              use2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              hazard,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sb_error
);

  localparam int NREG = 1 << ADDR_W;

  // Handshake contract: issue_en is a one-cycle strobe meaning "an instruction
  // writing issue_rd left OF this edge"; the producer must hold it low while
  // hazard=1. wb_en is a one-cycle strobe with no back-pressure (always accepted).

  logic [DATA_W-1:0] regs     [NREG];
  logic [1:0]        pend     [NREG];
  logic [1:0]        pend_nxt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic              err_set;
  logic              sb_error_q;
  logic              wb_hit1;
  logic              wb_hit2;
  logic              port1_busy;
  logic              port2_busy;

  // Register array; a write-back in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // One-hot decode of issue and write-back destinations.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_vec[i] = issue_en && (issue_rd == ADDR_W'(i));
      dec_vec[i] = wb_en && (wb_addr == ADDR_W'(i));
    end
  end

  // Saturating counters: overflow at 3 and underflow at 0 hold and flag an error.
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt[i] = pend[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (pend[i] == 2'd3) err_set = 1'b1;
        else                 pend_nxt[i] = pend[i] + 2'd1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (pend[i] == 2'd0) err_set = 1'b1;
        else                 pend_nxt[i] = pend[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= 2'd0;
      end
      sb_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= pend_nxt[i];
      end
      if (err_set) sb_error_q <= 1'b1;
    end
  end

  assign sb_error = sb_error_q;

  // Read ports with write-through bypass of the in-flight write-back.
  assign wb_hit1  = wb_en && (wb_addr == rd_addr1);
  assign wb_hit2  = wb_en && (wb_addr == rd_addr2);
  assign rd_data1 = wb_hit1 ? wb_data : regs[rd_addr1];
  assign rd_data2 = wb_hit2 ? wb_data : regs[rd_addr2];

  // The last outstanding write landing this cycle is bypassed, so it does not stall.
  assign port1_busy = use1 && (pend[rd_addr1] != 2'd0) &&
                      !(wb_hit1 && (pend[rd_addr1] == 2'd1));
  assign port2_busy = use2 && (pend[rd_addr2] != 2'd0) &&
                      !(wb_hit2 && (pend[rd_addr2] == 2'd1));
  assign hazard     = port1_busy || port2_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array/integer reference model of the register file.
module tb_reg_file_sb;

  localparam logic [31:0] SP_VAL = 32'h0000_0FFC;

  logic        clk;
  logic        reset;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        use1;
  logic        use2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        hazard;
  logic        issue_en;
  logic [3:0]  issue_rd;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_reg [16];
  int          m_pend[16];
  bit          m_err;
  logic [31:0] exp_q[$];

  reg_file_sb dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .use1     (use1),
    .use2     (use2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .hazard   (hazard),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .sb_error (sb_error)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset    = 1'b1;
    rd_addr1 = '0;
    rd_addr2 = '0;
    use1     = 1'b0;
    use2     = 1'b0;
    issue_en = 1'b0;
    issue_rd = '0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
  end

  // Model: what the read ports should show for the current inputs.
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  // Model: stall when a consumed operand still has writes outstanding, unless the
  // only remaining one is arriving right now.
  function automatic bit exp_busy(input bit u, input logic [3:0] a);
    int remaining;
    remaining = m_pend[a] - ((wb_en && wb_addr == a) ? 1 : 0);
    return u && (remaining > 0);
  endfunction

  // Apply one rising edge to the model and the DUT.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i]  = (i == 14) ? SP_VAL : 32'h0;
        m_pend[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        int p;
        p = m_pend[i] + ((issue_en && issue_rd == i) ? 1 : 0)
                      - ((wb_en && wb_addr == i) ? 1 : 0);
        if (p > 3) begin p = 3; m_err = 1'b1; end
        if (p < 0) begin p = 0; m_err = 1'b1; end
        m_pend[i] = p;
      end
      if (wb_en) m_reg[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    use1     = 1'b0;
    use2     = 1'b0;
    issue_en = 1'b0;
    wb_en    = 1'b0;
  endtask

  // Driver tasks
  task automatic do_issue(input logic [3:0] rd);
    set_idle();
    issue_en = 1'b1;
    issue_rd = rd;
    tick();
    set_idle();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd_addr1 = 4'd14;
    rd_addr2 = 4'd3;
    #1;
    checks++;
    if (rd_data1 !== SP_VAL) begin
      errors++; $display("FAIL reset_sp: got %h expected %h", rd_data1, SP_VAL);
    end
    checks++;
    if (rd_data2 !== 32'h0) begin
      errors++; $display("FAIL reset_r3: got %h expected %h", rd_data2, 32'h0);
    end
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL reset_hazard: got %b expected 0", hazard);
    end
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL reset_sb_error: got %b expected 0", sb_error);
    end
  endtask

  task automatic test_write_bypass();
    set_idle();
    wb_en    = 1'b1;
    wb_addr  = 4'd5;
    wb_data  = 32'hDEAD_BEEF;
    rd_addr1 = 4'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (rd_data1 !== exp_q[0]) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data1, exp_q[0]);
    end
    void'(exp_q.pop_front());
    // Write-back to r5 with nothing pending flags underflow; clear it afterwards.
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_data1 !== exp_q[0]) begin
      errors++; $display("FAIL write_stored: got %h expected %h", rd_data1, exp_q[0]);
    end
    void'(exp_q.pop_front());
    checks++;
    if (sb_error !== 1'b1) begin
      errors++; $display("FAIL underflow_r5: got %b expected 1", sb_error);
    end
    // Reset must keep nothing of r5's write.
    do_reset();
    rd_addr1 = 4'd5;
    #1;
    checks++;
    if (rd_data1 !== 32'h0) begin
      errors++; $display("FAIL reset_clears_r5: got %h expected 0", rd_data1);
    end
  endtask

  task automatic test_hazard_single();
    do_issue(4'd7);
    rd_addr2 = 4'd7;
    use2     = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL raw_r7_use: got %b expected 1", hazard);
    end
    use2 = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL raw_r7_nouse: got %b expected 0", hazard);
    end
    use2    = 1'b1;
    wb_en   = 1'b1;
    wb_addr = 4'd7;
    wb_data = 32'h11;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL wb_r7_hazard: got %b expected 0", hazard);
    end
    checks++;
    if (rd_data2 !== 32'h11) begin
      errors++; $display("FAIL wb_r7_data: got %h expected %h", rd_data2, 32'h11);
    end
    tick();
    set_idle();
  endtask

  task automatic test_multi_pending();
    do_issue(4'd4);
    do_issue(4'd4);
    rd_addr1 = 4'd4;
    use1     = 1'b1;
    wb_en    = 1'b1;
    wb_addr  = 4'd4;
    wb_data  = 32'hA5A5_0001;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL pend2_first_wb: got %b expected 1", hazard);
    end
    tick();
    wb_data = 32'hA5A5_0002;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL pend2_last_wb: got %b expected 0", hazard);
    end
    tick();
    wb_en = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b0 || rd_data1 !== 32'hA5A5_0002) begin
      errors++;
      $display("FAIL pend2_drained: got hz=%b data=%h expected hz=0 data=%h",
               hazard, rd_data1, 32'hA5A5_0002);
    end
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL pend2_no_error: got %b expected 0", sb_error);
    end
    set_idle();
  endtask

  task automatic test_sb_error();
    for (int k = 0; k < 3; k++) do_issue(4'd9);
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL issue3_no_error: got %b expected 0", sb_error);
    end
    do_issue(4'd9);
    checks++;
    if (sb_error !== 1'b1) begin
      errors++; $display("FAIL overflow_r9: got %b expected 1", sb_error);
    end
    // Counter saturated at 3: two write-backs leave one outstanding.
    for (int k = 0; k < 2; k++) begin
      wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h9;
      tick();
    end
    set_idle();
    rd_addr1 = 4'd9;
    use1     = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL r9_saturated: got %b expected 1", hazard);
    end
    wb_en = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL r9_last_wb: got %b expected 0", hazard);
    end
    tick();
    do_reset();
    #1;
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL reset_clears_error: got %b expected 0", sb_error);
    end
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h2;
    tick();
    set_idle();
    checks++;
    if (sb_error !== 1'b1) begin
      errors++; $display("FAIL underflow_r2: got %b expected 1", sb_error);
    end
    do_reset();
    #1;
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL reset_clears_error2: got %b expected 0", sb_error);
    end
  endtask

  task automatic test_same_cycle();
    do_issue(4'd6);
    issue_en = 1'b1;
    issue_rd = 4'd6;
    wb_en    = 1'b1;
    wb_addr  = 4'd6;
    wb_data  = 32'h66;
    rd_addr1 = 4'd6;
    use1     = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL same_cycle_bypass: got %b expected 0", hazard);
    end
    tick();
    set_idle();
    use1 = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL same_cycle_pend_kept: got %b expected 1", hazard);
    end
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h67;
    tick();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      rd_addr1 = 4'($urandom_range(0, 15));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 4'($urandom_range(0, 15));
      use1     = 1'($urandom_range(0, 1));
      use2     = 1'($urandom_range(0, 1));
      issue_en = ($urandom_range(0, 2) == 0);
      issue_rd = 4'($urandom_range(0, 3));
      wb_en    = ($urandom_range(0, 2) == 0);
      wb_addr  = ($urandom_range(0, 1) == 0) ? rd_addr1 : 4'($urandom_range(0, 15));
      wb_data  = $urandom;
      #1;
      exp_q.push_back(exp_rd(rd_addr1));
      checks++;
      if (rd_data1 !== exp_q[0]) begin
        errors++; $display("FAIL rand_rd1[%0d]: got %h expected %h", n, rd_data1, exp_q[0]);
      end
      void'(exp_q.pop_front());
      checks++;
      if (rd_data2 !== exp_rd(rd_addr2)) begin
        errors++;
        $display("FAIL rand_rd2[%0d]: got %h expected %h", n, rd_data2, exp_rd(rd_addr2));
      end
      checks++;
      if (hazard !== (exp_busy(use1, rd_addr1) || exp_busy(use2, rd_addr2))) begin
        errors++;
        $display("FAIL rand_hazard[%0d]: got %b expected %b", n, hazard,
                 exp_busy(use1, rd_addr1) || exp_busy(use2, rd_addr2));
      end
      checks++;
      if (sb_error !== m_err) begin
        errors++; $display("FAIL rand_sb_error[%0d]: got %b expected %b", n, sb_error, m_err);
      end
      tick();
    end
    reset = 1'b0;
    set_idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_write_bypass();
    test_hazard_single();
    test_multi_pending();
    test_sb_error();
    test_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
